// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter
// Shares one single-port word memory between three requesters: the
// program loader (highest priority), the MEM-stage data port and the
// IF-stage fetch port (lowest priority). A starvation counter lets fetch
// win after STARVE_MAX consecutive data wins. Only one access is in
// flight at a time, and it walks IDLE -> ISSUE -> [WAIT] -> CAPT -> RESP.
//
// Ports:
//   clk, RN                      clock (rising edge), async active-low reset
//   if_req/if_addr               fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata    fetch grant pulse, response pulse, data
//   dm_req/dm_we/dm_addr/dm_wdata  data request (held until dm_gnt)
//   dm_gnt/dm_rvalid/dm_rdata    data grant pulse, load data / store ack, data
//   ld_req/ld_addr/ld_wdata      loader write request (held until ld_gnt)
//   ld_gnt/ld_ack                loader grant pulse, write acknowledge
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
//   busy                         high whenever the FSM is not IDLE
module rv32i_mem_arbiter #(
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          RN,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int SCW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_MAX);
    // Last value of the WAIT counter; WAIT lasts MEM_LAT-1 cycles.
    localparam logic [1:0] WAIT_LAST = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, RESP} state_t;
    typedef enum logic [1:0] {OWN_IF, OWN_DM, OWN_LD} owner_t;

    state_t         state;
    owner_t         owner;
    logic           acc_we;
    logic [1:0]     wait_cnt;
    logic [SCW-1:0] starve_cnt;

    logic pick_ld;
    logic pick_dm;
    logic pick_if;

    // Fixed priority with a starvation override that lets fetch beat data
    // (but never the loader) once data has won STARVE_MAX times in a row.
    always_comb begin
        pick_ld = ld_req;
        pick_if = !ld_req && if_req && (!dm_req || (starve_cnt == STARVE_TOP));
        pick_dm = !ld_req && dm_req && !pick_if;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            acc_we     <= 1'b0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            dm_gnt     <= 1'b0;
            dm_rvalid  <= 1'b0;
            dm_rdata   <= '0;
            ld_gnt     <= 1'b0;
            ld_ack     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            // Grants, responses and the memory strobe are single-cycle pulses.
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            ld_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            ld_ack    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;

            case (state)
                IDLE, RESP: begin
                    // Loader grants leave the starvation count untouched.
                    if (!if_req || pick_if) begin
                        starve_cnt <= '0;
                    end else if (pick_dm && (starve_cnt != STARVE_TOP)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end

                    if (pick_ld) begin
                        owner     <= OWN_LD;
                        acc_we    <= 1'b1;
                        mem_addr  <= ld_addr;
                        mem_wdata <= ld_wdata;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        ld_gnt    <= 1'b1;
                        state     <= ISSUE;
                    end else if (pick_dm) begin
                        owner     <= OWN_DM;
                        acc_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_we;
                        dm_gnt    <= 1'b1;
                        state     <= ISSUE;
                    end else if (pick_if) begin
                        owner     <= OWN_IF;
                        acc_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_en    <= 1'b1;
                        if_gnt    <= 1'b1;
                        state     <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end

                ISSUE: begin
                    wait_cnt <= '0;
                    if (MEM_LAT > 1) begin
                        state <= WAIT;
                    end else begin
                        state <= CAPT;
                    end
                end

                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= CAPT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                CAPT: begin
                    // Read data lands in the owner's register; stores keep it.
                    state <= RESP;
                    case (owner)
                        OWN_LD: ld_ack <= 1'b1;
                        OWN_DM: begin
                            dm_rvalid <= 1'b1;
                            if (!acc_we) begin
                                dm_rdata <= mem_rdata;
                            end
                        end
                        default: begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    endcase
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter
// Directed bench for rv32i_mem_arbiter. Two instances: dut1 with
// MEM_LAT=1 for the functional scenarios and dut3 with MEM_LAT=3 for the
// WAIT-state, reset-abandon and latency scenarios. Each has a small
// behavioural memory with the matching read latency.
module tb_rv32i_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic RN;

    // dut1 (MEM_LAT = 1)
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          ld_req, ld_gnt, ld_ack;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [DW-1:0] mem1 [32];
    logic [109:0]  d1_outs;

    // dut3 (MEM_LAT = 3)
    logic          d3_if_req, d3_if_gnt, d3_if_rvalid;
    logic [AW-1:0] d3_if_addr;
    logic [DW-1:0] d3_if_rdata;
    logic          d3_dm_req, d3_dm_we, d3_dm_gnt, d3_dm_rvalid;
    logic [AW-1:0] d3_dm_addr;
    logic [DW-1:0] d3_dm_wdata, d3_dm_rdata;
    logic          d3_ld_gnt, d3_ld_ack;
    logic          d3_mem_en, d3_mem_we, d3_busy;
    logic [AW-1:0] d3_mem_addr;
    logic [DW-1:0] d3_mem_wdata, d3_mem_rdata;
    logic [DW-1:0] mem3 [32];
    logic [DW-1:0] p1, p2;
    logic [109:0]  d3_outs;

    int checks = 0;
    int errors = 0;

    assign d1_outs = {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
                      ld_gnt, ld_ack, mem_en, mem_we, mem_addr, mem_wdata, busy};
    assign d3_outs = {d3_if_gnt, d3_if_rvalid, d3_if_rdata, d3_dm_gnt, d3_dm_rvalid,
                      d3_dm_rdata, d3_ld_gnt, d3_ld_ack, d3_mem_en, d3_mem_we,
                      d3_mem_addr, d3_mem_wdata, d3_busy};

    rv32i_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(3)) dut1 (
        .clk(clk), .RN(RN),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_ack(ld_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    rv32i_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .STARVE_MAX(3)) dut3 (
        .clk(clk), .RN(RN),
        .if_req(d3_if_req), .if_addr(d3_if_addr), .if_gnt(d3_if_gnt),
        .if_rvalid(d3_if_rvalid), .if_rdata(d3_if_rdata),
        .dm_req(d3_dm_req), .dm_we(d3_dm_we), .dm_addr(d3_dm_addr),
        .dm_wdata(d3_dm_wdata), .dm_gnt(d3_dm_gnt), .dm_rvalid(d3_dm_rvalid),
        .dm_rdata(d3_dm_rdata),
        .ld_req(1'b0), .ld_addr(5'd0), .ld_wdata(32'd0),
        .ld_gnt(d3_ld_gnt), .ld_ack(d3_ld_ack),
        .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr),
        .mem_wdata(d3_mem_wdata), .mem_rdata(d3_mem_rdata), .busy(d3_busy)
    );

    // One-cycle read latency memory for dut1.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem1[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem1[mem_addr];
        end
    end

    // Three-cycle read latency memory for dut3 (address is held after ISSUE).
    always @(posedge clk) begin
        if (d3_mem_en && d3_mem_we) mem3[d3_mem_addr] <= d3_mem_wdata;
        p1           <= mem3[d3_mem_addr];
        p2           <= p1;
        d3_mem_rdata <= p2;
    end

    task automatic test_reset();
        logic seen;
        RN = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (d1_outs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_dut1 outputs=%h required=0", d1_outs);
        end
        checks++;
        if (d3_outs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_dut3 outputs=%h required=0", d3_outs);
        end
        RN = 1'b1;
        @(negedge clk);
        d3_dm_req = 1'b1; d3_dm_we = 1'b0; d3_dm_addr = 5'd5;
        @(negedge clk);
        checks++;
        if (d3_dm_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_setup_gnt got=%b required=1", d3_dm_gnt);
        end
        d3_dm_req = 1'b0;
        @(negedge clk);
        checks++;
        if (d3_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_setup_wait_busy got=%b required=1", d3_busy);
        end
        #2 RN = 1'b0;
        #1;
        checks++;
        if (d3_outs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_async outputs=%h required=0", d3_outs);
        end
        @(negedge clk);
        RN = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (d3_dm_rvalid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_abandon dm_rvalid_seen=%b required=0", seen);
        end
        d3_if_req = 1'b1; d3_if_addr = 5'd2;
        @(negedge clk);
        checks++;
        if (d3_if_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_next_gnt got=%b required=1", d3_if_gnt);
        end
        d3_if_req = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_single_fetch();
        ld_req = 1'b1; ld_addr = 5'd3; ld_wdata = 32'h02308300;
        @(negedge clk);
        checks++;
        if ({ld_gnt, mem_en, mem_we, mem_addr} !== {3'b111, 5'd3}) begin
            errors++;
            $display("[TB] FAIL loader_issue got=%b required=%b",
                     {ld_gnt, mem_en, mem_we, mem_addr}, {3'b111, 5'd3});
        end
        ld_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ld_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL loader_ack got=%b required=1", ld_ack);
        end
        if_req = 1'b1; if_addr = 5'd3;
        @(negedge clk);
        checks++;
        if ({if_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 5'd3}) begin
            errors++;
            $display("[TB] FAIL fetch_issue got=%b required=%b",
                     {if_gnt, mem_en, mem_we, mem_addr}, {3'b110, 5'd3});
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_rvalid, mem_en, busy} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL fetch_capt got=%b required=001", {if_rvalid, mem_en, busy});
        end
        @(negedge clk);
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h02308300}) begin
            errors++;
            $display("[TB] FAIL fetch_resp rvalid=%b rdata=%h required 1/02308300",
                     if_rvalid, if_rdata);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fetch_idle busy=%b required=0", busy);
        end
    endtask

    task automatic test_store_load();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 5'd4; dm_wdata = 32'd30;
        @(negedge clk);
        checks++;
        if ({dm_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 5'd4, 32'd30}) begin
            errors++;
            $display("[TB] FAIL store_issue gnt=%b en=%b we=%b addr=%0d wdata=%0d required 1/1/1/4/30",
                     dm_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        dm_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL store_we_after_issue got=%b required=0", mem_we);
        end
        @(negedge clk);
        checks++;
        if ({dm_rvalid, dm_rdata} !== {1'b1, 32'd0}) begin
            errors++;
            $display("[TB] FAIL store_ack rvalid=%b rdata=%h required 1/00000000",
                     dm_rvalid, dm_rdata);
        end
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 5'd4; dm_wdata = 32'd0;
        @(negedge clk);
        checks++;
        if ({dm_gnt, mem_en, mem_we} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL load_issue got=%b required=110", {dm_gnt, mem_en, mem_we});
        end
        dm_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dm_rvalid, dm_rdata} !== {1'b1, 32'd30}) begin
            errors++;
            $display("[TB] FAIL load_resp rvalid=%b rdata=%0d required 1/30", dm_rvalid, dm_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_priority();
        logic [5:0] obs, exp;
        ld_req = 1'b1; ld_addr = 5'd10; ld_wdata = 32'h0000000A;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 5'd4;
        if_req = 1'b1; if_addr = 5'd3;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            obs = {ld_gnt, dm_gnt, if_gnt, ld_ack, dm_rvalid, if_rvalid};
            case (k)
                1:       exp = 6'b100_000;
                3:       exp = 6'b000_100;
                4:       exp = 6'b010_000;
                6:       exp = 6'b000_010;
                7:       exp = 6'b001_000;
                9:       exp = 6'b000_001;
                default: exp = 6'b000_000;
            endcase
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL priority_cycle%0d got=%b required=%b", k, obs, exp);
            end
            if (k == 6) begin
                checks++;
                if (dm_rdata !== 32'd30) begin
                    errors++;
                    $display("[TB] FAIL priority_dm_rdata got=%0d required=30", dm_rdata);
                end
            end
            if (k == 9) begin
                checks++;
                if (if_rdata !== 32'h02308300) begin
                    errors++;
                    $display("[TB] FAIL priority_if_rdata got=%h required=02308300", if_rdata);
                end
            end
            if (ld_gnt) ld_req = 1'b0;
            if (dm_gnt) dm_req = 1'b0;
            if (if_gnt) if_req = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        logic [1:0] obs, exp;
        int stray;
        stray = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 5'd4;
        if_req = 1'b1; if_addr = 5'd3;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            obs = {dm_gnt, if_gnt};
            if ((k - 1) % 3 == 0) begin
                exp = ((((k - 1) / 3) % 4) == 3) ? 2'b01 : 2'b10;
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("[TB] FAIL starve_grant%0d got(dm,if)=%b required=%b",
                             (k - 1) / 3, obs, exp);
                end
            end else if (obs !== 2'b00 || ld_gnt !== 1'b0) begin
                stray++;
            end
            if (k == 24) begin
                dm_req = 1'b0;
                if_req = 1'b0;
            end
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("[TB] FAIL starve_stray_grants got=%0d required=0", stray);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_latency();
        logic [1:0] obs, exp;
        d3_dm_req = 1'b1; d3_dm_we = 1'b1; d3_dm_addr = 5'd7; d3_dm_wdata = 32'hCAFE0007;
        @(negedge clk);
        checks++;
        if ({d3_dm_gnt, d3_mem_en, d3_mem_we} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL lat_store_issue got=%b required=111",
                     {d3_dm_gnt, d3_mem_en, d3_mem_we});
        end
        d3_dm_req = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({d3_dm_rvalid, d3_dm_rdata} !== {1'b1, 32'd0}) begin
            errors++;
            $display("[TB] FAIL lat_store_ack rvalid=%b rdata=%h required 1/00000000",
                     d3_dm_rvalid, d3_dm_rdata);
        end
        @(negedge clk);
        d3_dm_req = 1'b1; d3_dm_we = 1'b0; d3_dm_addr = 5'd7;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            obs = {d3_busy, d3_dm_rvalid};
            exp = (k <= 4) ? 2'b10 : ((k == 5) ? 2'b11 : 2'b00);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL lat_cycle%0d got(busy,rvalid)=%b required=%b", k, obs, exp);
            end
            if (k == 5) begin
                checks++;
                if (d3_dm_rdata !== 32'hCAFE0007) begin
                    errors++;
                    $display("[TB] FAIL lat_rdata got=%h required=cafe0007", d3_dm_rdata);
                end
            end
            if (k == 1) d3_dm_req = 1'b0;
        end
    endtask

    initial begin
        RN = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
        d3_if_req = 1'b0; d3_if_addr = '0;
        d3_dm_req = 1'b0; d3_dm_we = 1'b0; d3_dm_addr = '0; d3_dm_wdata = '0;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_priority();
        test_starvation();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
